muldiv_unit: RTL and testbench

- Parametrised, iterative multiply/divide unit for the multicycle core; implements the RV32M op set (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at XLEN width.
- Sits beside the combinational ALU in the execute stage. The control FSM issues `start`, stalls on `busy`, and writes back `result` on `done`.
- Computes one bit per cycle: shift-add for multiply, restoring division for divide. Divide-by-zero and signed overflow take a 1-cycle fast path.

---
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute-stage control FSM and muldiv_unit.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (output start, op, a, b, input busy, done, result, zero);
    modport slave  (input start, op, a, b, output busy, done, result, zero);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one bit per cycle (shift-add / restoring divide).
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one iteration per cycle, cnt_q counts XLEN down to 1
// S_DONE | result valid, done pulse; start here issues back-to-back
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            a_sgn, b_sgn, fast;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic [XLEN:0]   mul_sum, div_sh, div_df;
    logic [XLEN-1:0] it_hi, it_lo, fin;
    logic [2*XLEN-1:0] prod, prod_f;

    // operand decode for a request presented on the bus
    always_comb begin
        a_sgn = bus.a[XLEN-1] & (bus.op == 3'b001 || bus.op == 3'b010 ||
                                 bus.op == 3'b100 || bus.op == 3'b110);
        b_sgn = bus.b[XLEN-1] & (bus.op == 3'b001 || bus.op == 3'b100 ||
                                 bus.op == 3'b110);
        a_mag = a_sgn ? -bus.a : bus.a;
        b_mag = b_sgn ? -bus.b : bus.b;
        fast  = 1'b0;
        fast_res = '0;
        if (bus.op[2] && bus.b == '0) begin
            fast     = 1'b1;
            fast_res = bus.op[1] ? bus.a : '1;
        end else if ((bus.op == 3'b100 || bus.op == 3'b110) &&
                     bus.a == MIN_NEG && bus.b == '1) begin
            fast     = 1'b1;
            fast_res = bus.op[1] ? '0 : bus.a;
        end
    end

    // one iteration of the datapath plus final sign fixup
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dsr_q} : '0);
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_df  = div_sh - {1'b0, dsr_q};
        if (op_q[2]) begin
            it_hi = div_df[XLEN] ? div_sh[XLEN-1:0] : div_df[XLEN-1:0];
            it_lo = {lo_q[XLEN-2:0], ~div_df[XLEN]};
        end else begin
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod   = {it_hi, it_lo};
        prod_f = neg_q ? -prod : prod;
        case (op_q)
            3'b000:         fin = prod_f[XLEN-1:0];
            3'b100, 3'b101: fin = neg_q ? -it_lo : it_lo;
            3'b110, 3'b111: fin = neg_q ? -it_hi : it_hi;
            default:        fin = prod_f[2*XLEN-1:XLEN];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    op_d  = bus.op;
                    // quotient and products follow sign(a)^sign(b); remainder follows sign(a)
                    neg_d = (bus.op[2] && bus.op[1]) ? a_sgn : (a_sgn ^ b_sgn);
                    hi_d  = '0;
                    lo_d  = a_mag;
                    dsr_d = b_mag;
                    if (fast) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d   = CW'(XLEN);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = fin;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dsr_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q == S_CALC);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.zero   = (result_q == '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called while in cycle T+k0; returns the cycle index of the done pulse (0 if none).
    task automatic wait_done(input int k0, output int done_at, output int busy_n);
        done_at = 0;
        busy_n  = 0;
        for (int k = k0; k <= 45 && done_at == 0; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done) done_at = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit fast);
        int done_at, busy_n;
        issue(op, a, b);
        wait_done(1, done_at, busy_n);
        chk({tag, "_done_cyc"}, 32'(done_at), fast ? 32'd1 : 32'd33);
        chk({tag, "_busy_cyc"}, 32'(busy_n), fast ? 32'd0 : 32'd32);
        chk({tag, "_result"}, bus.result, exp);
        chk({tag, "_zero"}, 32'(bus.zero), 32'(exp == 32'd0));
    endtask

    initial begin
        int done_at, busy_n;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd1);

        run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        @(posedge clk);
        #1;
        chk("mul_done_pulse", 32'(bus.done), 32'd0);
        chk("mul_result_hold", bus.result, 32'hFFFF_FFEB);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("mul0",   3'b000, 32'd0,         32'h1234_5678, 32'd0,         1'b0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("divu",   3'b101, 32'hFFFF_FFFE, 32'd3,         32'h5555_5554, 1'b0);
        run_op("remu",   3'b111, 32'hFFFF_FFFE, 32'd3,         32'd2,         1'b0);
        run_op("div_z",  3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1);
        run_op("remu_z", 3'b111, 32'd5,         32'd0,         32'd5,         1'b1);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);

        // start during CALC is ignored; start in the DONE cycle is accepted
        @(posedge clk);
        #1;
        issue(3'b000, 32'd5, 32'd6);
        repeat (4) @(posedge clk);
        #1;
        issue(3'b101, 32'd100, 32'd7);
        wait_done(6, done_at, busy_n);
        chk("hs_done_cyc", 32'(done_at), 32'd33);
        chk("hs_result", bus.result, 32'd30);
        issue(3'b101, 32'd10, 32'd3);
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        chk("b2b_done", 32'(bus.done), 32'd0);
        wait_done(1, done_at, busy_n);
        chk("b2b_done_cyc", 32'(done_at), 32'd33);
        chk("b2b_result", bus.result, 32'd3);

        // reset in the middle of a divide
        @(posedge clk);
        #1;
        issue(3'b100, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_result", bus.result, 32'd0);
        chk("mrst_zero", 32'(bus.zero), 32'd1);
        wait_done(1, done_at, busy_n);
        chk("mrst_no_done", 32'(done_at), 32'd0);
        chk("mrst_no_busy", 32'(busy_n), 32'd0);
        run_op("post_mulhu", 3'b011, 32'd2, 32'd3, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
